mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multicycle signed multiply/divide responder for the processor datapath. Accepts one-cycle start commands on `Mult`/`Div` from the control unit, iterates over 32 cycles on operands A and B, and returns completion on `MulttoControl`/`DivtoControl`. The 64-bit result is presented on `Hi`/`Lo` for the external Hi/Lo registers, which load it under `WriteHi`/`WriteLo`.

## Interface
- `WIDTH`, 32: operand width. Result is 2*WIDTH bits. Iteration count equals WIDTH.
- `Clock`, input, 1: single clock. All state changes on the rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Mult`, input, 2: multiply command. `01` = start. `00`, `10` and `11` = no operation.
- `Div`, input, 2: divide command. `01` = start. `00`, `10` and `11` = no operation.
- `A`, input, WIDTH: multiplicand or dividend. Sampled only on the accepted start edge.
- `B`, input, WIDTH: multiplier or divisor. Sampled only on the accepted start edge.
- `MulttoControl`, output, 1: multiply done. One-cycle pulse.
- `DivtoControl`, output, 2: divide status. `00` = none, `01` = done, `10` = divide-by-zero. Each non-zero code is a one-cycle pulse.
- `Hi`, output, WIDTH: multiply upper product, or divide remainder.
- `Lo`, output, WIDTH: multiply lower product, or divide quotient.
- `Busy`, output, 1: high while in state MULT or DIV.

## Operation
- **States:** IDLE, MULT, DIV, DONE_M, DONE_D, DZERO.
- **Reset value (`Reset`=0):** state IDLE, counter 0. All outputs 0: `Hi`, `Lo`, `MulttoControl`, `DivtoControl`, `Busy`. Takes effect immediately, asynchronously.
- **IDLE:**
  - `Mult`==`01` → latch A and B, clear accumulator, go to MULT.
  - Else `Div`==`01` and B==0 → go to DZERO.
  - Else `Div`==`01` → latch |A| and |B| plus both sign bits, go to DIV.
  - If `Mult` and `Div` both start in the same cycle, `Mult` wins and the divide is dropped.
- **MULT:** radix-2 Booth, signed. One step per cycle. Accumulator is 2*WIDTH+1 bits, with an arithmetic shift right each step. After WIDTH steps → DONE_M.
- **DIV:** restoring division on magnitudes, one quotient bit per cycle. After WIDTH steps, apply signs:
  - quotient is negated if the signs of A and B differ;
  - remainder takes the sign of A.
  - Then go to DONE_D.
- **DONE_M:** `MulttoControl`=1 for this cycle only, then IDLE.
- **DONE_D:** `DivtoControl`=`01` for this cycle only, then IDLE.
- **DZERO:** `DivtoControl`=`10` for this cycle only. `Hi`/`Lo` unchanged. Then IDLE.
- **Start commands outside IDLE** are ignored. The operation in progress is not disturbed, and no second done pulse is produced.
- **Result update:** `Hi`/`Lo` change only on the edge that enters DONE_M or DONE_D. Otherwise they hold the previous result.
- **Width and overflow rules:**
  - Multiply yields the full signed 2*WIDTH product, so no overflow is possible.
  - Divide of 0x80000000 / 0xFFFFFFFF wraps: `Lo`=0x80000000, `Hi`=0. No status is reported.
- **Reset mid-operation:** abort with no done pulse. `Hi`/`Lo` are cleared to 0.

## Timing
- Start is accepted on rising edge E0 while in IDLE.
- **Multiply or divide:**
  - `Busy`=1 from E0 to E32.
  - `Hi`/`Lo` are valid from E32.
  - The done pulse is high from E32 to E33.
  - The unit is back in IDLE at E33 and can accept a new start at E33. Earliest back-to-back start is therefore 33 cycles apart.
- **Divide-by-zero:** `DivtoControl`=`10` from E0 to E1. `Busy` stays 0. Back in IDLE at E1.
- **Output registration:** all outputs are registered. There is no combinational path from inputs to outputs.
- **Control-side hold:** the control unit holds A and B only for the start cycle. Operands are internally latched from then on.

## Test plan
- **Basic multiply:** `Mult`=01, A=7, B=0xFFFFFFFD (−3) → `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFEB. `MulttoControl` pulses exactly once, 32 cycles after the start edge. `Busy` is high for 32 cycles.
- **Extreme multiply:** `Mult`=01, A=B=0x80000000 → `Hi`=0x40000000, `Lo`=0. Then A=0xFFFFFFFF, B=0xFFFFFFFF → `Hi`=0, `Lo`=1.
- **Signed divide:**
  - `Div`=01, A=0xFFFFFFF9 (−7), B=2 → `Lo`=0xFFFFFFFD (−3), `Hi`=0xFFFFFFFF (−1), `DivtoControl`=01 for one cycle.
  - A=100, B=7 → `Lo`=14, `Hi`=2.
- **Divide by zero and wrap:**
  - Prior result `Hi`=2, `Lo`=14; then `Div`=01, A=5, B=0 → `DivtoControl`=10 on the cycle after start, `Hi`=2 and `Lo`=14 unchanged, `Busy` never set.
  - A=0x80000000, B=0xFFFFFFFF → `Lo`=0x80000000, `Hi`=0.
- **Simultaneous and ignored starts:**
  - `Mult`=01 and `Div`=01 in the same cycle with A=6, B=3 → product result (`Lo`=18), `MulttoControl` pulses, `DivtoControl` stays 00.
  - `Div`=01 issued at cycle 10 of a multiply → ignored, exactly one `MulttoControl` pulse.
- **Reset mid-operation:** assert `Reset`=0 at cycle 10 of a divide → `Hi`/`Lo`/`Busy`/status all 0 immediately, and no done pulse after release. A new multiply 5×5 after release gives `Lo`=25.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) / divide (restoring) responder
//   Clock, Reset (async, active low)
//   Mult, Div      : 2-bit start commands, 01 = start (Mult wins if both start)
//   A, B           : operands, sampled only on the accepted start edge
//   MulttoControl  : multiply-done pulse
//   DivtoControl   : 01 = divide done, 10 = divide by zero (one-cycle pulses)
//   Hi, Lo         : product upper/lower, or remainder/quotient
//   Busy           : high while iterating
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [1:0]       Mult,
    input  logic [1:0]       Div,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             MulttoControl,
    output logic [1:0]       DivtoControl,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, MULT, DIV, DONE_M, DONE_D, DZERO} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] m_reg;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             sign_a;
    logic             sign_b;

    // Booth step: the add is done one bit wider than the upper half so that
    // subtracting the most negative multiplicand cannot overflow before the shift.
    logic [WIDTH:0]   upper_ext;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] acc_n;

    always_comb begin
        upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        sum = acc[1:0] == 2'b01 ? upper_ext + {m_reg[WIDTH-1], m_reg} :
              acc[1:0] == 2'b10 ? upper_ext - {m_reg[WIDTH-1], m_reg} : upper_ext;
        acc_n = {sum, acc[WIDTH:1]};
    end

    // Restoring step: the dividend shifts out of quo into rem while quotient bits shift in.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff = shifted - {1'b0, m_reg};
        fits = shifted >= {1'b0, m_reg};
        rem_n = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            m_reg         <= '0;
            acc           <= '0;
            rem           <= '0;
            quo           <= '0;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            MulttoControl <= 1'b0;
            DivtoControl  <= 2'b00;
            Hi            <= '0;
            Lo            <= '0;
            Busy          <= 1'b0;
        end else begin
            MulttoControl <= 1'b0;
            DivtoControl  <= 2'b00;
            case (state)
                MULT: begin
                    acc <= acc_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state         <= DONE_M;
                        Busy          <= 1'b0;
                        MulttoControl <= 1'b1;
                        Hi            <= acc_n[2*WIDTH:WIDTH+1];
                        Lo            <= acc_n[WIDTH:1];
                    end
                end
                DIV: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state        <= DONE_D;
                        Busy         <= 1'b0;
                        DivtoControl <= 2'b01;
                        Lo           <= (sign_a ^ sign_b) ? -quo_n : quo_n;
                        Hi           <= sign_a ? -rem_n : rem_n;
                    end
                end
                // The single-cycle done states return to IDLE and accept a new
                // start on the same edge, giving 33-cycle back-to-back spacing.
                default: begin
                    if (Mult == 2'b01) begin
                        state <= MULT;
                        Busy  <= 1'b1;
                        cnt   <= '0;
                        m_reg <= A;
                        acc   <= {{WIDTH{1'b0}}, B, 1'b0};
                    end else if (Div == 2'b01 && B == '0) begin
                        state        <= DZERO;
                        DivtoControl <= 2'b10;
                    end else if (Div == 2'b01) begin
                        state  <= DIV;
                        Busy   <= 1'b1;
                        cnt    <= '0;
                        m_reg  <= B[WIDTH-1] ? -B : B;
                        quo    <= A[WIDTH-1] ? -A : A;
                        rem    <= '0;
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against a plain-arithmetic reference model
module tb_mult_div_unit;
    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [1:0]   Mult = 2'b00;
    logic [1:0]   Div = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         MulttoControl;
    logic [1:0]   DivtoControl;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         Busy;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Mult(Mult),
        .Div(Div),
        .A(A),
        .B(B),
        .MulttoControl(MulttoControl),
        .DivtoControl(DivtoControl),
        .Hi(Hi),
        .Lo(Lo),
        .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // kind: 0 = multiply done, 1 = divide done, 2 = divide by zero
    typedef struct {
        int           kind;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           compared = 0;
    int           mismatched = 0;
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int now);
        longint sa, sv, p, q, r;
        exp_t e;
        sa = longint'($signed(a));
        sv = longint'($signed(b));
        e.due = now + 33;
        e.hi = '0;
        e.lo = '0;
        if (m == 2'b01) begin
            p = sa * sv;
            e.kind = 0;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == '0) begin
            e.kind = 2;
            e.due = now + 1;
        end else begin
            q = sa / sv;
            r = sa % sv;
            e.kind = 1;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Monitor: samples 1 time unit after each falling clock edge or reset assertion.
    always @(negedge Clock or negedge Reset) begin
        exp_t e;
        int   ak;
        logic exp_busy;
        #1;
        if (!Reset) begin
            check("reset_result", {Hi, Lo}, 64'd0);
            check("reset_flags", {60'd0, Busy, MulttoControl, DivtoControl}, 64'd0);
            sb.delete();
            cur_hi = '0;
            cur_lo = '0;
        end else begin
            exp_busy = sb.size() > 0 && sb[0].kind != 2 && cyc >= sb[0].due - 32 && cyc < sb[0].due;
            check("busy", 64'(Busy), 64'(exp_busy));
            if (MulttoControl || DivtoControl != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {61'd0, MulttoControl, DivtoControl}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    ak = (MulttoControl && DivtoControl == 2'b00) ? 0 :
                         (!MulttoControl && DivtoControl == 2'b01) ? 1 :
                         (!MulttoControl && DivtoControl == 2'b10) ? 2 : 3;
                    check("status", 64'(ak), 64'(e.kind));
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    if (e.kind != 2) begin
                        cur_hi = e.hi;
                        cur_lo = e.lo;
                    end
                    check("result", {Hi, Lo}, {cur_hi, cur_lo});
                end
            end else begin
                check("hold", {Hi, Lo}, {cur_hi, cur_lo});
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    check("missing_done", 64'(cyc), 64'(sb[0].due));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [1:0] d,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clock);
        Mult = m;
        Div = d;
        A = a;
        B = b;
        if (m == 2'b01 || d == 2'b01) sb.push_back(model(m, a, b, cyc));
        @(negedge Clock);
        Mult = 2'b00;
        Div = 2'b00;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge Clock);
        @(negedge Clock);
    endtask

    function automatic logic [W-1:0] pick();
        int sel;
        sel = $urandom_range(0, 5);
        return sel == 0 ? 32'h0 : sel == 1 ? 32'h1 : sel == 2 ? 32'hFFFF_FFFF :
               sel == 3 ? 32'h8000_0000 : sel == 4 ? W'($urandom_range(0, 20)) : W'($urandom);
    endfunction

    initial begin
        logic [1:0] m;
        logic [1:0] d;
        int r;
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;

        issue(2'b01, 2'b00, 32'd7, 32'hFFFF_FFFD);
        wait_idle();
        issue(2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_idle();
        issue(2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        issue(2'b00, 2'b01, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        issue(2'b00, 2'b01, 32'd100, 32'd7);
        wait_idle();
        issue(2'b00, 2'b01, 32'd5, 32'd0);
        wait_idle();
        issue(2'b00, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(2'b01, 2'b01, 32'd6, 32'd3);
        wait_idle();

        // Starts issued mid-operation must be ignored.
        issue(2'b01, 2'b00, $urandom, $urandom);
        repeat (8) @(negedge Clock);
        Div = 2'b01;
        Mult = 2'b01;
        B = 32'd3;
        @(negedge Clock);
        Div = 2'b00;
        Mult = 2'b00;
        wait_idle();

        // Reset in the middle of a divide.
        issue(2'b00, 2'b01, $urandom, $urandom | 32'd1);
        repeat (9) @(negedge Clock);
        #3 Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (40) @(negedge Clock);
        issue(2'b01, 2'b00, 32'd5, 32'd5);
        wait_idle();

        repeat (40) begin
            r = $urandom_range(0, 2);
            m = 2'($urandom_range(0, 3));
            d = 2'($urandom_range(0, 3));
            if (r == 0) m = 2'b01;
            if (r == 1) begin
                d = 2'b01;
                if (m == 2'b01) m = 2'b00;
            end
            issue(m, d, pick(), pick());
            wait_idle();
        end

        repeat (5) @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
